// File: rtl/fwd_frame_emitter_pkg.sv
// Shared types and constants for the forwarding frame emitter.
// Optional build macro used by the emitter: FWD_PAD_EN (pad short frames
// up to the minimum length instead of dropping them).
package fwd_pkg;

  // Frame buffer / replay state machine encoding.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILL    = 3'd1,
    ST_DISCARD = 3'd2,
    ST_READY   = 3'd3,
    ST_SEND    = 3'd4
  } fwd_state_e;

  // Control block layout: the frame length appears twice.
  localparam int CTRL_LEN_HI  = 23;
  localparam int CTRL_LEN_LO  = 12;
  localparam int CTRL_LEN2_HI = 11;
  localparam int CTRL_LEN2_LO = 0;

  // Default frame length limits and buffer address width.
  localparam int DEF_MIN_LEN = 64;
  localparam int DEF_MAX_LEN = 1518;
  localparam int DEF_AW      = 11;

  // Length / pointer counters are one bit wider than the 12-bit length field
  // so that "one past MAX_LEN" never wraps back into the legal range.
  localparam int CNT_W = 13;
  localparam logic [CNT_W-1:0] CNT_ONE = 13'd1;
  localparam logic [CNT_W-1:0] CNT_TWO = 13'd2;

  // Saturating add of a small increment to the 16-bit drop counter.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'd0, inc};
    if (sum[16]) begin
      return 16'hFFFF;
    end else begin
      return sum[15:0];
    end
  endfunction

endpackage

// File: rtl/fwd_frame_emitter_if.sv
// Byte-stream handshake from the forwarding logic into the emitter.
// master = byte source, slave = emitter.
interface fwd_frame_emitter_if;
  logic       s_valid;
  logic       s_sof;
  logic       s_eof;
  logic [7:0] s_data;
  logic       s_hi;
  logic       s_ready;

  modport master (
    output s_valid, s_sof, s_eof, s_data, s_hi,
    input  s_ready
  );

  modport slave (
    input  s_valid, s_sof, s_eof, s_data, s_hi,
    output s_ready
  );
endinterface

// File: rtl/fwd_frame_emitter_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port
// (read data appears one clock after the address is presented).
module fwd_frame_ram #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  localparam int unsigned DEPTH = 32'd1 << AW;

  logic [7:0] mem_r [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    rd_data <= mem_r[rd_addr];
  end

endmodule

// File: rtl/fwd_frame_emitter.sv
// Store-and-forward stage ahead of the transmitter: buffers one whole frame,
// checks its length, then replays it on the f_* interface as a control-block
// strobe plus a gapless run of data bytes.
// Build macro: FWD_PAD_EN -- when defined, short frames are padded with
// zero bytes up to MIN_LEN and sent instead of dropped.
module fwd_frame_emitter
  import fwd_pkg::*;
#(
  parameter int MIN_LEN = DEF_MIN_LEN,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int AW      = DEF_AW
) (
  input  logic                clk_sys,
  input  logic                reset,
  fwd_frame_emitter_if.slave  s,
  input  logic                x_hold,
  output logic                f_rec_frame_valid,
  output logic [23:0]         f_ctrl_in,
  output logic                f_rec_data_valid,
  output logic [7:0]          f_data_in,
  output logic                f_hi_priority,
  output logic [15:0]         drop_cnt
);

  fwd_state_e       state_r;
  logic             s_ready_r;
  logic [CNT_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] len_r;
  logic [CNT_W-1:0] send_len_r;
  logic [CNT_W-1:0] idx_r;
  logic             hi_r;
  logic [7:0]       byte0_r;

  logic             accept_s;
  logic             restart_s;
  logic             in_fill_s;
  logic             frame_end_s;
  logic             overflow_s;
  logic             discard_end_s;
  logic [CNT_W-1:0] chk_len_s;
  logic             runt_s;
  logic             too_long_s;
  logic             keep_s;
  logic [CNT_W-1:0] send_len_s;
  logic [1:0]       drop_inc_s;
  logic             we_s;
  logic [AW-1:0]    wr_addr_s;
  logic [AW-1:0]    rd_addr_s;
  logic [7:0]       rd_data_s;

  assign s.s_ready = s_ready_r;

  // Decode this cycle's input events, the length check and the RAM controls.
  always_comb begin
    accept_s      = s.s_valid & s_ready_r;
    restart_s     = accept_s & s.s_sof;
    in_fill_s     = (state_r == ST_FILL);
    frame_end_s   = accept_s & s.s_eof & (s.s_sof | in_fill_s);
    overflow_s    = accept_s & in_fill_s & ~s.s_sof & ~s.s_eof &
                    (wr_ptr_r >= CNT_W'(MAX_LEN));
    discard_end_s = accept_s & (state_r == ST_DISCARD) & s.s_eof & ~s.s_sof;

    // An SOF byte always starts a fresh frame, so a SOF+EOF byte is length 1.
    if (s.s_sof) begin
      chk_len_s = CNT_ONE;
    end else begin
      chk_len_s = wr_ptr_r + CNT_ONE;
    end
    runt_s     = (chk_len_s < CNT_W'(MIN_LEN));
    too_long_s = (chk_len_s > CNT_W'(MAX_LEN));

`ifdef FWD_PAD_EN
    keep_s = ~too_long_s;
    if (runt_s) begin
      send_len_s = CNT_W'(MIN_LEN);
    end else begin
      send_len_s = chk_len_s;
    end
`else
    keep_s     = ~runt_s & ~too_long_s;
    send_len_s = chk_len_s;
`endif

    // A restart outside IDLE abandons the frame in progress; a rejected
    // length or the end of a discarded frame also counts as a drop.
    drop_inc_s = {1'b0, restart_s & (state_r != ST_IDLE)} +
                 {1'b0, frame_end_s & ~keep_s} +
                 {1'b0, discard_end_s};

    // Bytes past MAX_LEN are never written, so the buffer cannot wrap.
    we_s = restart_s |
           (accept_s & in_fill_s & ~s.s_sof & (wr_ptr_r < CNT_W'(MAX_LEN)));
    if (restart_s) begin
      wr_addr_s = '0;
    end else begin
      wr_addr_s = AW'(wr_ptr_r);
    end

    // Byte 0 comes from byte0_r, so the RAM prefetches one byte ahead:
    // address 1 while waiting, then idx+2 while byte idx is on the outputs.
    if (state_r == ST_SEND) begin
      rd_addr_s = AW'(idx_r + CNT_TWO);
    end else begin
      rd_addr_s = AW'(CNT_ONE);
    end
  end

  fwd_frame_ram #(
    .AW (AW)
  ) u_ram (
    .clk     (clk_sys),
    .we      (we_s),
    .wr_addr (wr_addr_s),
    .wr_data (s.s_data),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s)
  );

  // Frame buffer / replay state machine with registered outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_r           <= ST_IDLE;
      s_ready_r         <= 1'b1;
      wr_ptr_r          <= '0;
      len_r             <= '0;
      send_len_r        <= '0;
      idx_r             <= '0;
      hi_r              <= 1'b0;
      byte0_r           <= 8'h00;
      f_rec_frame_valid <= 1'b0;
      f_ctrl_in         <= 24'h000000;
      f_rec_data_valid  <= 1'b0;
      f_data_in         <= 8'h00;
      f_hi_priority     <= 1'b0;
      drop_cnt          <= 16'h0000;
    end else begin
      drop_cnt <= sat_add16(drop_cnt, drop_inc_s);
      if (restart_s) begin
        hi_r    <= s.s_hi;
        byte0_r <= s.s_data;
      end

      case (state_r)
        ST_IDLE, ST_FILL, ST_DISCARD: begin
          if (frame_end_s) begin
            len_r      <= chk_len_s;
            send_len_r <= send_len_s;
            if (keep_s) begin
              state_r   <= ST_READY;
              s_ready_r <= 1'b0;
            end else begin
              state_r <= ST_IDLE;
            end
          end else if (restart_s) begin
            state_r  <= ST_FILL;
            wr_ptr_r <= CNT_ONE;
          end else if (overflow_s) begin
            state_r <= ST_DISCARD;
          end else if (discard_end_s) begin
            state_r <= ST_IDLE;
          end else if (accept_s && in_fill_s) begin
            wr_ptr_r <= wr_ptr_r + CNT_ONE;
          end
        end

        ST_READY: begin
          if (!x_hold) begin
            state_r           <= ST_SEND;
            idx_r             <= '0;
            f_rec_frame_valid <= 1'b1;
            f_ctrl_in[CTRL_LEN_HI:CTRL_LEN_LO]   <= send_len_r[11:0];
            f_ctrl_in[CTRL_LEN2_HI:CTRL_LEN2_LO] <= send_len_r[11:0];
            f_rec_data_valid  <= 1'b1;
            f_data_in         <= byte0_r;
            f_hi_priority     <= hi_r;
          end
        end

        ST_SEND: begin
          if (idx_r == send_len_r - CNT_ONE) begin
            state_r           <= ST_IDLE;
            s_ready_r         <= 1'b1;
            f_rec_frame_valid <= 1'b0;
            f_ctrl_in         <= 24'h000000;
            f_rec_data_valid  <= 1'b0;
            f_data_in         <= 8'h00;
            f_hi_priority     <= 1'b0;
          end else begin
            idx_r             <= idx_r + CNT_ONE;
            f_rec_frame_valid <= 1'b0;
            f_ctrl_in         <= 24'h000000;
            // Positions past the received length are pad bytes.
            if (idx_r + CNT_ONE < len_r) begin
              f_data_in <= rd_data_s;
            end else begin
              f_data_in <= 8'h00;
            end
          end
        end

        default: begin
          state_r   <= ST_IDLE;
          s_ready_r <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fwd_frame_emitter.sv
// Directed bench for fwd_frame_emitter with an expected-byte scoreboard.
module tb_fwd_frame_emitter;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        x_hold;
  logic        f_rec_frame_valid;
  logic [23:0] f_ctrl_in;
  logic        f_rec_data_valid;
  logic [7:0]  f_data_in;
  logic        f_hi_priority;
  logic [15:0] drop_cnt;

  fwd_frame_emitter_if sif ();

  fwd_frame_emitter #(
    .MIN_LEN (MIN_LEN),
    .MAX_LEN (MAX_LEN),
    .AW      (11)
  ) dut (
    .clk_sys           (clk_sys),
    .reset             (reset),
    .s                 (sif),
    .x_hold            (x_hold),
    .f_rec_frame_valid (f_rec_frame_valid),
    .f_ctrl_in         (f_ctrl_in),
    .f_rec_data_valid  (f_rec_data_valid),
    .f_data_in         (f_data_in),
    .f_hi_priority     (f_hi_priority),
    .drop_cnt          (drop_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic        fv;
    logic [23:0] ctrl;
    logic [7:0]  data;
    logic        hi;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] cur_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         exp_drop = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int kind, input int i, input int len);
    if (kind == 0) begin
      return (i < 4 || i >= len - 4) ? 8'h00 : 8'hFF;
    end else begin
      return 8'((i * 7 + 3) & 255);
    end
  endfunction

  // Drive one frame byte per cycle; ends on the negedge after the last byte.
  task automatic send_frame(input int len, input logic hi, input int kind, input bit with_eof);
    logic [7:0] b;
    cur_q.delete();
    for (int i = 0; i < len; i++) begin
      b = pat(kind, i, len);
      @(negedge clk_sys);
      sif.s_valid = 1'b1;
      sif.s_sof   = (i == 0);
      sif.s_eof   = with_eof && (i == len - 1);
      sif.s_data  = b;
      sif.s_hi    = hi;
      cur_q.push_back(b);
    end
    @(negedge clk_sys);
    sif.s_valid = 1'b0;
    sif.s_sof   = 1'b0;
    sif.s_eof   = 1'b0;
  endtask

  // Turn the frame just driven into expected output bytes, or a drop.
  task automatic expect_frame(input logic hi);
    int   len;
    int   sl;
    bit   keep;
    exp_t e;
    len = cur_q.size();
    sl  = len;
`ifdef FWD_PAD_EN
    keep = (len <= MAX_LEN);
    if (len < MIN_LEN) sl = MIN_LEN;
`else
    keep = (len >= MIN_LEN) && (len <= MAX_LEN);
`endif
    if (!keep) begin
      exp_drop++;
    end else begin
      for (int k = 0; k < sl; k++) begin
        e.fv   = (k == 0);
        e.ctrl = (k == 0) ? {sl[11:0], sl[11:0]} : 24'h000000;
        e.data = (k < len) ? cur_q[k] : 8'h00;
        e.hi   = hi;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_fv"},   f_rec_frame_valid, 1'b0);
    check({tag, "_ctrl"}, f_ctrl_in, 24'h000000);
    check({tag, "_dv"},   f_rec_data_valid, 1'b0);
    check({tag, "_data"}, f_data_in, 8'h00);
    check({tag, "_hi"},   f_hi_priority, 1'b0);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys);
      check("quiet_dv", f_rec_data_valid, 1'b0);
      check("quiet_fv", f_rec_frame_valid, 1'b0);
    end
  endtask

  // Wait (bounded) for the control strobe, then pop one entry per cycle.
  task automatic collect(input int exp_lat, input int hold_at, input int reset_at);
    int   lat;
    int   k;
    exp_t e;
    lat = 1;
    while (f_rec_frame_valid !== 1'b1 && lat < 60) begin
      @(negedge clk_sys);
      lat++;
    end
    check("latency", lat, exp_lat);
    if (f_rec_frame_valid !== 1'b1) begin
      exp_q.delete();
    end
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("dvalid", f_rec_data_valid, 1'b1);
      check("fvalid", f_rec_frame_valid, e.fv);
      check("ctrl",   f_ctrl_in, e.ctrl);
      check("data",   f_data_in, e.data);
      check("hi",     f_hi_priority, e.hi);
      if (k == hold_at) x_hold = 1'b1;
      if (k == reset_at) begin
        reset = 1'b1;
        exp_q.delete();
      end
      k++;
      @(negedge clk_sys);
    end
    check_idle("after_frame");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    x_hold      = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_sof   = 1'b0;
    sif.s_eof   = 1'b0;
    sif.s_data  = 8'h00;
    sif.s_hi    = 1'b0;
    repeat (3) @(negedge clk_sys);
    check_idle("reset");
    check("reset_drop", drop_cnt, 16'd0);
    reset = 1'b0;

    // 64-byte pattern frame, high priority.
    send_frame(64, 1'b1, 0, 1'b1);
    expect_frame(1'b1);
    collect(2, -1, -1);
    check("t1_drop", drop_cnt, exp_drop);

    // 40-byte runt.
    send_frame(40, 1'b0, 1, 1'b1);
    expect_frame(1'b0);
`ifdef FWD_PAD_EN
    collect(2, -1, -1);
`else
    quiet(6);
`endif
    check("runt_drop", drop_cnt, exp_drop);

    // Oversize frame goes to DISCARD, then a 100-byte frame.
    send_frame(1600, 1'b1, 1, 1'b1);
    expect_frame(1'b1);
    quiet(4);
    check("long_drop", drop_cnt, exp_drop);
    send_frame(100, 1'b1, 1, 1'b1);
    expect_frame(1'b1);
    collect(2, -1, -1);
    check("len100_drop", drop_cnt, exp_drop);

    // Exactly MAX_LEN is kept, one more is dropped.
    send_frame(MAX_LEN, 1'b0, 1, 1'b1);
    expect_frame(1'b0);
    collect(2, -1, -1);
    send_frame(MAX_LEN + 1, 1'b0, 1, 1'b1);
    expect_frame(1'b0);
    quiet(4);
    check("max1_drop", drop_cnt, exp_drop);

    // Transmitter held for 10 cycles; hold raised again mid-frame.
    x_hold = 1'b1;
    send_frame(64, 1'b1, 0, 1'b1);
    expect_frame(1'b1);
    for (int i = 0; i < 10; i++) begin
      check("hold_ready", sif.s_ready, 1'b0);
      check("hold_dv", f_rec_data_valid, 1'b0);
      check("hold_fv", f_rec_frame_valid, 1'b0);
      @(negedge clk_sys);
    end
    x_hold = 1'b0;
    // Strobe expected on the very next cycle after the hold drops.
    collect(2, 10, -1);
    x_hold = 1'b0;

    // SOF at byte 30 restarts with a new, low-priority frame.
    send_frame(30, 1'b1, 1, 1'b0);
    exp_drop++;
    send_frame(64, 1'b0, 1, 1'b1);
    expect_frame(1'b0);
    collect(2, -1, -1);
    check("restart_drop", drop_cnt, exp_drop);

    // Reset at byte 20 of SEND, then a normal frame.
    send_frame(64, 1'b1, 1, 1'b1);
    expect_frame(1'b1);
    collect(2, -1, 20);
    check("rst_drop", drop_cnt, 16'd0);
    reset    = 1'b0;
    exp_drop = 0;
    send_frame(64, 1'b0, 0, 1'b1);
    expect_frame(1'b0);
    collect(2, -1, -1);
    check("final_drop", drop_cnt, exp_drop);

    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
